// File: rtl/mem_pkg.sv
// Shared definitions for the SDRAM arbiter clients: state type and bus-size defaults.
package mem_pkg;

    localparam int MEM_AN    = 24;
    localparam int MEM_DN    = 16;
    localparam int MEM_BURST = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_WR,
        ST_NEXT
    } mem_blit_state_t;

endpackage

// File: rtl/mem_blit_buf.sv
// BURST x DN staging buffer for one read burst: sequential fill from the arbiter,
// sequential drain towards the write phase, with look-ahead of the next word.
module blit_buf #(
    parameter int DN    = 16,
    parameter int BURST = 8,
    localparam int IW   = (BURST > 1) ? $clog2(BURST) : 1,
    localparam int CW   = $clog2(BURST + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [DN-1:0] wr_data_i,
    input  logic          rd_adv_i,
    output logic          wr_last_o,
    output logic [DN-1:0] rd_data_o,
    output logic [DN-1:0] rd_next_o
);

    logic [DN-1:0] mem_q [BURST];
    logic [CW-1:0] wr_cnt_q;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] rd_nxt;
    logic [IW-1:0] wr_idx;

    assign wr_idx    = wr_cnt_q[IW-1:0];
    assign rd_nxt    = (rd_idx_q == IW'(BURST - 1)) ? '0 : rd_idx_q + 1'b1;
    assign wr_last_o = wr_en_i && (wr_cnt_q == CW'(BURST - 1));
    // Write-through so word 0 is visible even when it lands on the final strobe.
    assign rd_data_o = (wr_en_i && (wr_idx == rd_idx_q)) ? wr_data_i : mem_q[rd_idx_q];
    assign rd_next_o = mem_q[rd_nxt];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q <= '0;
            rd_idx_q <= '0;
        end else if (clear_i) begin
            wr_cnt_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_en_i) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (rd_adv_i) begin
                rd_idx_q <= rd_nxt;
            end
        end
    end

endmodule

// File: rtl/mem_blit.sv
// Rectangle block-copy client for the SDRAM arbiter: burst reads into blit_buf, single-word writes.
// Optional solid-colour fill mode is enabled by defining MEM_BLIT_FILL_EN.
module mem_blit
    import mem_pkg::*;
#(
    parameter int AN    = MEM_AN,
    parameter int DN    = MEM_DN,
    parameter int BURST = MEM_BURST,
    parameter int WN    = 10,
    parameter int HN    = 9,
    parameter int LS    = 800
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          start,
    input  logic [AN-1:0] src,
    input  logic [AN-1:0] dst,
    input  logic [WN-1:0] width,
    input  logic [HN-1:0] height,
`ifdef MEM_BLIT_FILL_EN
    input  logic          fill,
    input  logic [DN-1:0] colour,
`endif
    input  logic [DN-1:0] mem_data,
    input  logic          mem_valid,
    output logic [AN-1:0] req_addr,
    output logic [DN-1:0] req_data,
    output logic          req,
    output logic          req_wr,
    input  logic          req_ack,
    output logic          busy,
    output logic          done
);

    mem_blit_state_t state_q;
    logic [AN-1:0]   src_row_q, dst_row_q, req_addr_q;
    logic [WN-1:0]   col_q, width_q, word_q;
    logic [HN-1:0]   rows_q;
    logic [DN-1:0]   req_data_q, colour_q;
    logic            req_q, req_wr_q, busy_q, done_q, fill_q;

    logic            fill_s;
    logic [DN-1:0]   colour_s;
`ifdef MEM_BLIT_FILL_EN
    assign fill_s   = fill;
    assign colour_s = colour;
`else
    assign fill_s   = 1'b0;
    assign colour_s = '0;
`endif

    logic [WN-1:0] rem, chunk, word_nxt;
    logic [AN-1:0] src_nrow, dst_nrow;
    logic          wr_last;
    logic          buf_last;
    logic [DN-1:0] buf_rd_data, buf_rd_next;

    assign rem      = width_q - col_q;
    assign chunk    = (rem > WN'(BURST)) ? WN'(BURST) : rem;
    assign word_nxt = word_q + 1'b1;
    assign wr_last  = (word_nxt == chunk);
    assign src_nrow = src_row_q + AN'(LS);
    assign dst_nrow = dst_row_q + AN'(LS);

    blit_buf #(.DN(DN), .BURST(BURST)) u_buf (
        .clk_i     (clkSYS),
        .rst_ni    (n_reset),
        .clear_i   (state_q == ST_RD_REQ),
        .wr_en_i   ((state_q == ST_RD_DATA) && mem_valid),
        .wr_data_i (mem_data),
        .rd_adv_i  ((state_q == ST_WR) && req_ack && !fill_q),
        .wr_last_o (buf_last),
        .rd_data_o (buf_rd_data),
        .rd_next_o (buf_rd_next)
    );

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            src_row_q  <= '0;
            dst_row_q  <= '0;
            req_addr_q <= '0;
            col_q      <= '0;
            width_q    <= '0;
            word_q     <= '0;
            rows_q     <= '0;
            req_data_q <= '0;
            colour_q   <= '0;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fill_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if ((width == '0) || (height == '0)) begin
                            done_q <= 1'b1;
                        end else begin
                            src_row_q <= src;
                            dst_row_q <= dst;
                            col_q     <= '0;
                            word_q    <= '0;
                            width_q   <= width;
                            rows_q    <= height;
                            fill_q    <= fill_s;
                            colour_q  <= colour_s;
                            busy_q    <= 1'b1;
                            req_q     <= 1'b1;
                            if (fill_s) begin
                                state_q    <= ST_WR;
                                req_wr_q   <= 1'b1;
                                req_addr_q <= dst;
                                req_data_q <= colour_s;
                            end else begin
                                state_q    <= ST_RD_REQ;
                                req_wr_q   <= 1'b0;
                                req_addr_q <= src;
                            end
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (req_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (buf_last) begin
                        state_q    <= ST_WR;
                        req_q      <= 1'b1;
                        req_wr_q   <= 1'b1;
                        req_addr_q <= dst_row_q + AN'(col_q);
                        req_data_q <= buf_rd_data;
                        word_q     <= '0;
                    end
                end
                ST_WR: begin
                    if (req_ack) begin
                        if (wr_last) begin
                            req_q   <= 1'b0;
                            col_q   <= col_q + chunk;
                            state_q <= ST_NEXT;
                        end else begin
                            word_q     <= word_nxt;
                            req_addr_q <= dst_row_q + AN'(col_q) + AN'(word_nxt);
                            req_data_q <= fill_q ? colour_q : buf_rd_next;
                        end
                    end
                end
                ST_NEXT: begin
                    word_q <= '0;
                    if (col_q < width_q) begin
                        req_q <= 1'b1;
                        if (fill_q) begin
                            state_q    <= ST_WR;
                            req_wr_q   <= 1'b1;
                            req_addr_q <= dst_row_q + AN'(col_q);
                            req_data_q <= colour_q;
                        end else begin
                            state_q    <= ST_RD_REQ;
                            req_wr_q   <= 1'b0;
                            req_addr_q <= src_row_q + AN'(col_q);
                        end
                    end else if (rows_q == HN'(1)) begin
                        rows_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        src_row_q <= src_nrow;
                        dst_row_q <= dst_nrow;
                        col_q     <= '0;
                        rows_q    <= rows_q - 1'b1;
                        req_q     <= 1'b1;
                        if (fill_q) begin
                            state_q    <= ST_WR;
                            req_wr_q   <= 1'b1;
                            req_addr_q <= dst_nrow;
                            req_data_q <= colour_q;
                        end else begin
                            state_q    <= ST_RD_REQ;
                            req_wr_q   <= 1'b0;
                            req_addr_q <= src_nrow;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_addr = req_addr_q;
    assign req_data = req_data_q;
    assign req      = req_q;
    assign req_wr   = req_wr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mem_blit.sv
// Scoreboarded bench for mem_blit: randomised arbiter timing, sparse memory model,
// expected traffic derived from the rectangle geometry.
module tb_mem_blit;

    localparam int AN = 24, DN = 16, BURST = 8, WN = 10, HN = 9, LS = 800;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic [AN-1:0] src, dst;
    logic [WN-1:0] width;
    logic [HN-1:0] height;
`ifdef MEM_BLIT_FILL_EN
    logic          fill_in;
    logic [DN-1:0] colour_in;
`endif
    logic [DN-1:0] mem_data;
    logic          mem_valid;
    logic [AN-1:0] req_addr;
    logic [DN-1:0] req_data;
    logic          req, req_wr, req_ack, busy, done;

    always #5 clk = ~clk;

    mem_blit dut (
        .clkSYS    (clk),
        .n_reset   (n_reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .width     (width),
        .height    (height),
`ifdef MEM_BLIT_FILL_EN
        .fill      (fill_in),
        .colour    (colour_in),
`endif
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req       (req),
        .req_wr    (req_wr),
        .req_ack   (req_ack),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [AN-1:0] addr;
        logic [DN-1:0] data;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            rd_seen = 0;
    int            wr_seen = 0;
    wr_t           wr_exp[$];
    logic [AN-1:0] rd_exp[$];
    logic [AN-1:0] rd_pend[$];
    logic [DN-1:0] mem_m [logic [AN-1:0]];
    int            dly_min = 0, dly_max = 0, gap_max = 0;
    int            wait_cnt = 0;

    function automatic logic [DN-1:0] init_val(input logic [AN-1:0] a);
        return a[15:0] ^ {a[23:16], 8'hA5};
    endfunction

    function automatic logic [DN-1:0] mem_rd(input logic [AN-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return init_val(a);
    endfunction

    // Arbiter model: acts on the falling edge so the DUT sees stable inputs at the rising edge.
    initial begin
        req_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            req_ack   = 1'b0;
            mem_valid = 1'b0;
            mem_data  = DN'($urandom);
            if (rd_pend.size() > 0 && $urandom_range(gap_max, 0) == 0) begin
                mem_valid = 1'b1;
                mem_data  = mem_rd(rd_pend.pop_front());
            end
            if (!n_reset) begin
                wait_cnt = dly_min;
            end else if (req) begin
                if (wait_cnt <= 0) begin
                    req_ack = 1'b1;
                    if (!req_wr) begin
                        for (int b = 0; b < BURST; b++) begin
                            logic [AN-1:0] a;
                            a = req_addr + AN'(b);
                            rd_pend.push_back(a);
                        end
                    end
                    wait_cnt = $urandom_range(dly_max, dly_min);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks request hold while waiting.
    initial begin
        logic          prev_wait;
        logic [AN+DN+1:0] prev_vec;
        prev_wait = 1'b0;
        prev_vec  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (n_reset && prev_wait) begin
                checks++;
                if ({req, req_wr, req_addr, req_data} !== prev_vec) begin
                    errors++;
                    $display("FAIL hold: got %h required %h", {req, req_wr, req_addr, req_data}, prev_vec);
                end
            end
            if (req && req_ack) begin
                checks++;
                if (req_wr) begin
                    wr_seen++;
                    if (wr_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h data=%h required none", req_addr, req_data);
                    end else begin
                        wr_t e;
                        e = wr_exp.pop_front();
                        if (req_addr !== e.addr || req_data !== e.data) begin
                            errors++;
                            $display("FAIL write: got %h:%h required %h:%h", req_addr, req_data, e.addr, e.data);
                        end
                    end
                    mem_m[req_addr] = req_data;
                end else begin
                    rd_seen++;
                    if (rd_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read: addr=%h required none", req_addr);
                    end else begin
                        logic [AN-1:0] ea;
                        ea = rd_exp.pop_front();
                        if (req_addr !== ea) begin
                            errors++;
                            $display("FAIL read_addr: got %h required %h", req_addr, ea);
                        end
                    end
                end
            end
            prev_wait = n_reset && req && !req_ack;
            prev_vec  = {req, req_wr, req_addr, req_data};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: every destination word of the rectangle gets either the colour or the source word.
    task automatic push_expected(input logic [AN-1:0] s, input logic [AN-1:0] d,
                                 input int w, input int h, input logic f, input logic [DN-1:0] col);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                wr_t e;
                logic [AN-1:0] sa;
                sa     = s + AN'(r * LS + c);
                e.addr = d + AN'(r * LS + c);
                e.data = f ? col : mem_rd(sa);
                wr_exp.push_back(e);
            end
            if (!f) begin
                for (int c = 0; c < w; c += BURST) begin
                    logic [AN-1:0] ra;
                    ra = s + AN'(r * LS + c);
                    rd_exp.push_back(ra);
                end
            end
        end
    endtask

    task automatic run_op(input logic [AN-1:0] s, input logic [AN-1:0] d, input int w, input int h,
                          input logic f, input logic [DN-1:0] col, input string name);
        int  rd0, wr0, exp_rd, exp_wr;
        bit  got;
        rd0    = rd_seen;
        wr0    = wr_seen;
        exp_wr = (w == 0 || h == 0) ? 0 : w * h;
        exp_rd = (w == 0 || h == 0 || f) ? 0 : h * ((w + BURST - 1) / BURST);
        push_expected(s, d, w, h, f, col);
        @(negedge clk); #3;
        src = s; dst = d; width = WN'(w); height = HN'(h); start = 1'b1;
`ifdef MEM_BLIT_FILL_EN
        fill_in = f; colour_in = col;
`endif
        @(negedge clk); #3;
        start = 1'b0;
        checks++;
        if (exp_wr == 0) begin
            if (done !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin
                errors++;
                $display("FAIL %s_empty_done: done=%b busy=%b req=%b required 1 0 0", name, done, busy, req);
            end
        end else begin
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_rise: busy=%b done=%b required 1 0", name, busy, done);
            end
            got = 1'b0;
            for (int n = 0; n < 20000 && !got; n++) begin
                @(negedge clk); #3;
                if (done === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL %s_timeout: done never seen, required within 20000 cycles", name);
            end else if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_at_done: busy=%b required 0", name, busy);
            end
        end
        @(negedge clk); #3;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b required 0 0", name, done, busy);
        end
        checks++;
        if (rd_seen - rd0 != exp_rd || wr_seen - wr0 != exp_wr) begin
            errors++;
            $display("FAIL %s_counts: reads=%0d writes=%0d required %0d %0d",
                     name, rd_seen - rd0, wr_seen - wr0, exp_rd, exp_wr);
        end
        wr_exp.delete();
        rd_exp.delete();
        $display("op %-8s src=%h dst=%h w=%0d h=%0d reads=%0d writes=%0d",
                 name, s, d, w, h, rd_seen - rd0, wr_seen - wr0);
    endtask

    initial begin
        int  rd0, wr0;
        bit  hit, bad;
        n_reset = 1'b0;
        start   = 1'b0;
        src = '0; dst = '0; width = '0; height = '0;
`ifdef MEM_BLIT_FILL_EN
        fill_in = 1'b0; colour_in = '0;
`endif
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if ({req, req_wr, req_addr, req_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h required 0", {req, req_wr, req_addr, req_data, busy, done});
        end
        n_reset = 1'b1;

        dly_min = 0; dly_max = 0; gap_max = 0; wait_cnt = 0;
        run_op(24'h000000, 24'h001000, 8, 2, 1'b0, '0, "basic");
        run_op(24'h000000, 24'h002000, 11, 1, 1'b0, '0, "partial");
        checks++;
        if (mem_m.exists(24'h00200B)) begin
            errors++;
            $display("FAIL partial_untouched: dst+11 written with %h required untouched", mem_m[24'h00200B]);
        end
        run_op(24'h000100, 24'h003000, 0, 5, 1'b0, '0, "zero_w");
        run_op(24'h000100, 24'h003000, 7, 0, 1'b0, '0, "zero_h");

        dly_min = 5; dly_max = 5; gap_max = 3; wait_cnt = 5;
        run_op(24'h010000, 24'h820000, 13, 3, 1'b0, '0, "slow");

        dly_min = 0; dly_max = 2; gap_max = 1; wait_cnt = 0;
        run_op(24'hFFFFFC, 24'hFFFC00, 20, 2, 1'b0, '0, "wrap_src");
        run_op(24'h500000, 24'hFFFFF8, 16, 1, 1'b0, '0, "wrap_dst");

        // Reset in the middle of a read burst; leftover strobes must be ignored.
        dly_min = 1; dly_max = 2; gap_max = 3; wait_cnt = 1;
        rd0 = rd_seen;
        wr0 = wr_seen;
        rd_exp.push_back(24'h040000);
        @(negedge clk); #3;
        src = 24'h040000; dst = 24'h840000; width = WN'(24); height = HN'(2); start = 1'b1;
        @(negedge clk); #3;
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk); #3;
            if (rd_seen > rd0 && mem_valid) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_reach_rd_data: no read data seen, required within 200 cycles");
        end
        n_reset = 1'b0;
        @(negedge clk); #3;
        checks++;
        if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_op: req=%b busy=%b done=%b required 0 0 0", req, busy, done);
        end
        @(negedge clk); #3;
        n_reset = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 200 && (rd_pend.size() > 0 || n < 20); n++) begin
            @(negedge clk); #3;
            if (req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || wr_seen != wr0 || rd_pend.size() != 0) begin
            errors++;
            $display("FAIL rst_stray: active=%b writes=%0d pending=%0d required 0 0 0",
                     bad, wr_seen - wr0, rd_pend.size());
        end
        rd_exp.delete();
        wr_exp.delete();
        run_op(24'h040000, 24'h840000, 24, 2, 1'b0, '0, "post_rst");

`ifdef MEM_BLIT_FILL_EN
        dly_min = 0; dly_max = 1; gap_max = 0; wait_cnt = 0;
        run_op(24'h000000, 24'hFA0000, 4, 3, 1'b1, 16'hF800, "fill");
`endif

        for (int i = 0; i < 8; i++) begin
            logic [AN-1:0] s, d;
            s = AN'($urandom_range(32'h6FFFFF, 0));
            d = 24'h800000 + AN'($urandom_range(32'h3F0000, 0));
            dly_min = 0;
            dly_max = $urandom_range(3, 0);
            gap_max = $urandom_range(2, 0);
            run_op(s, d, $urandom_range(40, 1), $urandom_range(4, 1), 1'b0, '0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
